mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS datapath: decodes the instruction held in the instruction register and sequences the datapath through FETCH/DECODE/EXEC/MEM/WB, driving the 4-bit ALU operation code, mux selects and write enables. It consumes the ALU's `IsEq` flag to resolve `beq`. It sits between the instruction register and the datapath control pins, replacing the single-cycle combinational controller.

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_decode.sv | 44 ++++
 rtl/mc_ctrl.sv | 145 ++++++++++++++
 tb/tb_mc_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs,
// ALU operation codes (also used by the ALU), datapath select encodings,
// FSM state enum and the one-hot instruction class produced by mc_decode.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_LUI  = 4'b0100;

    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_DM   = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_J    = 2'b10;
    localparam logic [1:0] NPC_JR   = 2'b11;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Exactly one bit is set for any instruction word; nop is the all-zero
    // word, unk is every encoding outside the supported set.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic jal;
        logic jr;
        logic nop;
        logic unk;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: maps the IR word to a one-hot instruction class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input word continuously.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0] instr,
    output iclass_t     cls
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_zero;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign is_zero = ~|instr;

    // Classify by opcode, and by funct for R-type words.
    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    default: begin
                        cls.nop = is_zero;
                        cls.unk = ~is_zero;
                    end
                endcase
            end
            OP_JAL:  cls.jal = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            default: cls.unk = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) driving datapath pins.
// Latency: 2 cycles jal/jr/nop, 3 beq, 4 addu/subu/ori/lui/sw, 5 lw.
// Backpressure: with MC_CTRL_MEMWAIT_EN defined, MEM stalls while MemReady=0; otherwise none.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        IsEq,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  ALUOp,
    output logic        ALUSrc,
    output logic        ExtOp,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic [1:0]  NPCSel,
    output logic        InstrDone
);

    state_t  state;
    state_t  state_nxt;
    iclass_t cls;
    logic    mem_go;

    mc_decode u_decode (
        .instr (Instr),
        .cls   (cls)
    );

`ifdef MC_CTRL_MEMWAIT_EN
    assign mem_go = MemReady;
`else
    // MemReady has no effect: MEM always completes in one cycle.
    assign mem_go = 1'b1 | MemReady;
`endif

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next state and datapath controls from state plus decoded class.
    always_comb begin
        state_nxt = state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        ALUOp     = ALU_ADD;
        ALUSrc    = 1'b0;
        ExtOp     = 1'b0;
        RegDst    = RD_RT;
        MemToReg  = M2R_ALU;
        NPCSel    = NPC_PC4;
        InstrDone = 1'b0;

        // ALU setup persists from EXEC through MEM and WB so the result stays valid.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            if (cls.subu || cls.beq)      ALUOp = ALU_SUB;
            else if (cls.ori)             ALUOp = ALU_OR;
            else if (cls.lui)             ALUOp = ALU_LUI;
            else                          ALUOp = ALU_ADD;
            ALUSrc = cls.ori | cls.lui | cls.lw | cls.sw;
            ExtOp  = cls.lw | cls.sw | cls.beq;
        end

        case (state)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                NPCSel    = NPC_PC4;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (cls.jal) begin
                    // PC already holds PC+4, which is the link value.
                    PCWrite   = 1'b1;
                    NPCSel    = NPC_J;
                    RegWrite  = 1'b1;
                    RegDst    = RD_RA;
                    MemToReg  = M2R_PC;
                    InstrDone = 1'b1;
                    state_nxt = S_FETCH;
                end else if (cls.jr) begin
                    PCWrite   = 1'b1;
                    NPCSel    = NPC_JR;
                    InstrDone = 1'b1;
                    state_nxt = S_FETCH;
                end else if (cls.nop || cls.unk) begin
                    InstrDone = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls.beq) begin
                    PCWrite   = IsEq;
                    NPCSel    = NPC_BR;
                    InstrDone = 1'b1;
                    state_nxt = S_FETCH;
                end else if (cls.lw || cls.sw) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (mem_go) begin
                    if (cls.sw) begin
                        MemWrite  = 1'b1;
                        InstrDone = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                RegDst    = (cls.addu || cls.subu) ? RD_RD : RD_RT;
                MemToReg  = cls.lw ? M2R_DM : M2R_ALU;
                InstrDone = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase

        // No write may escape while reset is held, wherever the FSM was.
        if (reset) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction behavioural model (phase list per
// instruction class, outputs per phase) with directed test-plan cases,
// literal pins on the model, then randomized instruction streams with
// occasional mid-instruction resets.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        IsEq;
    logic        MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, ALUSrc, ExtOp, InstrDone;
    logic [3:0]  ALUOp;
    logic [1:0]  RegDst, MemToReg, NPCSel;

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic [3:0] aluop;
        logic       alusrc;
        logic       extop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic [1:0] npcsel;
        logic       done;
    } out_t;

    typedef enum int {C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_NOP} cls_t;
    typedef enum int {P_F, P_D, P_E, P_M, P_W, P_WAIT} ph_t;

    int   n_vec = 0;
    int   n_err = 0;
    out_t snap [0:15];

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Instr     (Instr),
        .IsEq      (IsEq),
        .MemReady  (MemReady),
        .PCWrite   (PCWrite),
        .IRWrite   (IRWrite),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .ALUOp     (ALUOp),
        .ALUSrc    (ALUSrc),
        .ExtOp     (ExtOp),
        .RegDst    (RegDst),
        .MemToReg  (MemToReg),
        .NPCSel    (NPCSel),
        .InstrDone (InstrDone)
    );

    function automatic out_t dut_out();
        out_t o;
        o = {PCWrite, IRWrite, RegWrite, MemWrite, ALUOp, ALUSrc, ExtOp,
             RegDst, MemToReg, NPCSel, InstrDone};
        return o;
    endfunction

    function automatic cls_t classify(input logic [31:0] w);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) begin
            if (fn == 6'h21) return C_ADDU;
            if (fn == 6'h23) return C_SUBU;
            if (fn == 6'h08) return C_JR;
            return C_NOP;
        end
        case (op)
            6'h03:   return C_JAL;
            6'h04:   return C_BEQ;
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            default: return C_NOP;
        endcase
    endfunction

    // Cycles per instruction class.
    function automatic int ncyc(input cls_t c);
        case (c)
            C_JAL, C_JR, C_NOP: return 2;
            C_BEQ:              return 3;
            C_LW:               return 5;
            default:            return 4;
        endcase
    endfunction

    // Which phase the k-th cycle of an instruction is (memory waits excluded).
    function automatic ph_t phase_at(input cls_t c, input int k);
        case (k)
            0:       return P_F;
            1:       return P_D;
            2:       return P_E;
            3:       return (c == C_LW || c == C_SW) ? P_M : P_W;
            default: return P_W;
        endcase
    endfunction

    // Required outputs for a class in a phase.
    function automatic out_t expect_out(input cls_t c, input ph_t p, input logic eq);
        out_t e;
        e = '0;
        if (p == P_F) begin
            e.pcw = 1'b1;
            e.irw = 1'b1;
        end else if (p == P_D) begin
            if (c == C_JAL) begin
                e.pcw = 1'b1; e.npcsel = 2'b10; e.rw = 1'b1;
                e.regdst = 2'b10; e.memtoreg = 2'b10; e.done = 1'b1;
            end else if (c == C_JR) begin
                e.pcw = 1'b1; e.npcsel = 2'b11; e.done = 1'b1;
            end else if (c == C_NOP) begin
                e.done = 1'b1;
            end
        end else begin
            case (c)
                C_SUBU:     e.aluop = 4'b0001;
                C_BEQ:      begin e.aluop = 4'b0001; e.extop = 1'b1; end
                C_ORI:      begin e.aluop = 4'b0011; e.alusrc = 1'b1; end
                C_LUI:      begin e.aluop = 4'b0100; e.alusrc = 1'b1; end
                C_LW, C_SW: begin e.alusrc = 1'b1; e.extop = 1'b1; end
                default:    ;
            endcase
            if (p == P_E && c == C_BEQ) begin
                e.pcw = eq; e.npcsel = 2'b01; e.done = 1'b1;
            end
            if (p == P_M && c == C_SW) begin
                e.mw = 1'b1; e.done = 1'b1;
            end
            if (p == P_W) begin
                e.rw       = 1'b1;
                e.regdst   = (c == C_ADDU || c == C_SUBU) ? 2'b01 : 2'b00;
                e.memtoreg = (c == C_LW) ? 2'b01 : 2'b00;
                e.done     = 1'b1;
            end
        end
        return e;
    endfunction

    // Compare DUT outputs to the model mid-cycle, then advance to just after the next edge.
    task automatic check(input string nm, input out_t e, input int k);
        out_t a;
        @(negedge clk);
        a = dut_out();
        if (k >= 0 && k < 16) snap[k] = a;
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, a, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Drive one instruction from its FETCH; cyc returns cycles until the DUT's
    // first InstrDone (0 if none, -1 if aborted by reset at cycle abort_at).
    task automatic run_instr(input logic [31:0] ins, input logic eq, input int abort_at,
                             input int nwait, output int cyc);
        cls_t c;
        int   n;
        int   k;
        c   = classify(ins);
        n   = ncyc(c);
        k   = 0;
        cyc = 0;
        for (int i = 0; i < 16; i++) snap[i] = '0;
        for (int i = 0; i < n; i++) begin
            ph_t p;
            p        = phase_at(c, i);
            Instr    = (i == 0) ? $urandom : ins;
            IsEq     = (p == P_E) ? eq : 1'($urandom);
            MemReady = 1'($urandom);
            if (i == abort_at) begin
                reset = 1'b1;
                check("reset_abort", '0, -1);
                reset = 1'b0;
                cyc   = -1;
                return;
            end
`ifdef MC_CTRL_MEMWAIT_EN
            if (p == P_M) begin
                int w;
                w = (nwait < 0) ? int'($urandom_range(0, 3)) : nwait;
                for (int j = 0; j < w; j++) begin
                    MemReady = 1'b0;
                    check($sformatf("%s_memwait", c.name()), expect_out(c, P_WAIT, eq), k);
                    k++;
                end
                MemReady = 1'b1;
            end
`else
            if (nwait > 0) $display("note: memory wait ignored in this build");
`endif
            check($sformatf("%s_cyc%0d", c.name(), i), expect_out(c, p, eq), k);
            k++;
        end
        for (int i = k - 1; i >= 0; i--) if (snap[i].done) cyc = i + 1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:       return {6'h00, r[25:6], 6'h21};
            1:       return {6'h00, r[25:6], 6'h23};
            2:       return {6'h00, r[25:6], 6'h08};
            3:       return {6'h0D, r[25:0]};
            4:       return {6'h23, r[25:0]};
            5:       return {6'h2B, r[25:0]};
            6:       return {6'h04, r[25:0]};
            7:       return {6'h0F, r[25:0]};
            8:       return {6'h03, r[25:0]};
            9:       return 32'h0;
            default: return r;
        endcase
    endfunction

    initial begin
        int          cyc;
        int          mw_cnt;
        logic [31:0] w;
        int          ab;

        reset    = 1'b1;
        Instr    = 32'h0;
        IsEq     = 1'b0;
        MemReady = 1'b0;
        check("reset_hold", '0, -1);
        check("reset_hold", '0, -1);
        reset = 1'b0;

        run_instr(32'h0, 1'b0, -1, 0, cyc);
        lit("nop_cycles", cyc, 2);
        lit("nop_fetch_en", {snap[0].irw, snap[0].pcw}, 2'b11);

        run_instr(32'h00221821, 1'b0, -1, 0, cyc);
        lit("addu_cycles", cyc, 4);
        lit("addu_exec", {snap[2].aluop, snap[2].alusrc}, 5'b0000_0);
        lit("addu_wb", {snap[3].rw, snap[3].regdst}, 3'b1_01);

        run_instr(32'h8C220004, 1'b0, -1, 0, cyc);
        lit("lw_cycles", cyc, 5);
        lit("lw_mem_nowrite", snap[3].mw, 0);
        lit("lw_wb", {snap[4].memtoreg, snap[4].regdst, snap[4].extop}, 5'b01_00_1);

        run_instr(32'h10220003, 1'b1, -1, 0, cyc);
        lit("beq_cycles", cyc, 3);
        lit("beq_taken", {snap[2].pcw, snap[2].npcsel, snap[2].aluop}, 7'b1_01_0001);
        run_instr(32'h10220003, 1'b0, -1, 0, cyc);
        lit("beq_not_taken_pcw", snap[2].pcw, 0);

        run_instr(32'h0C000010, 1'b0, -1, 0, cyc);
        lit("jal_cycles", cyc, 2);
        lit("jal_decode", {snap[1].pcw, snap[1].npcsel, snap[1].rw, snap[1].regdst,
                           snap[1].memtoreg}, 8'b1_10_1_10_10);

        run_instr(32'hAC220008, 1'b0, 3, 0, cyc);
        lit("sw_abort", cyc, 32'hFFFF_FFFF);
        run_instr(32'h00221821, 1'b0, -1, 0, cyc);
        lit("after_abort_cycles", cyc, 4);

`ifdef MC_CTRL_MEMWAIT_EN
        run_instr(32'hAC220008, 1'b0, -1, 3, cyc);
        lit("sw_wait_cycles", cyc, 7);
        mw_cnt = 0;
        for (int i = 0; i < 16; i++) mw_cnt += int'(snap[i].mw);
        lit("sw_wait_mw_pulses", mw_cnt, 1);
`else
        mw_cnt = 0;
`endif

        for (int t = 0; t < 400; t++) begin
            w  = rand_instr();
            ab = -1;
            if ($urandom_range(0, 19) == 0) ab = $urandom_range(0, ncyc(classify(w)) - 1);
            run_instr(w, 1'($urandom), ab, -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
